csa_share_arbiter: RTL
======================

Name: csa_share_arbiter

Overview:
- Shares one 16-bit carry-select add/subtract unit (CSA: A, B, mod, Y, overflow) among NREQ requesters.
- Arbitrates round-robin, latches the winner's operands and opcode, and drives the CSA from registers.
- Captures Y and carry-out, then returns them on a valid/ready response channel tagged with the requester index.
- Sits between the datapath clients and the single shared CSA instance, which it instantiates internally.

Parameters:
- NREQ, 4: number of requesters; legal range 2..8.
- IDW, 2: width of the requester-index tag; must be at least clog2(NREQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request strobe.
- req_op  in  NREQ  per-requester opcode: 0 = add, 1 = subtract (drives CSA mod).
- req_a  in  16*NREQ  operand A; requester i occupies bits [16i+15:16i].
- req_b  in  16*NREQ  operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot grant pulse; the request is consumed in that cycle.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_y  out  16  sum or difference (A+B, or A+~B+1).
- rsp_cout  out  1  CSA carry-out; for subtract this is 1 when there is no borrow.
- busy  out  1  high in EXEC and RESP.
- op_count  out  16  count of completed responses (rsp_valid & rsp_ready); wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE; rr_ptr = 0.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_y = 0, rsp_cout = 0, busy = 0, op_count = 0.
  - Operand and op registers = 0.
- States: IDLE, EXEC, RESP. Only one operation is outstanding at a time.
- Arbitration window: the cycle is in IDLE, or the cycle is in RESP with rsp_ready=1.
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[winner] = 1 combinationally in that cycle; all other req_ready bits stay 0.
  - At the clock edge: latch req_a, req_b, req_op and the winner index; set rr_ptr = (winner+1) mod NREQ; go to EXEC.
  - If no req_valid bit is set: IDLE stays IDLE, and RESP with rsp_ready=1 goes to IDLE. rr_ptr is unchanged.
- Requester rules:
  - A requester holds req_valid and its operands stable until it sees req_ready.
  - Deasserting req_valid before the grant is legal and withdraws the request.
  - Operands are sampled only in the grant cycle.
- EXEC (exactly one cycle):
  - The CSA is fed from the latched registers: A = a_reg, B = b_reg, mod = op_reg.
  - At the edge: rsp_y = Y, rsp_cout = overflow, rsp_id = latched index; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_y, rsp_cout and rsp_id are held stable until the handshake.
  - rsp_valid & rsp_ready: op_count increments and the arbitration window applies in the same cycle.
  - Back-to-back throughput is one operation per 2 cycles.
- Latency: grant in cycle T -> rsp_valid first high in cycle T+2.
- Simultaneous events:
  - A response handshake and a new grant in the same cycle are allowed.
  - rsp_valid drops to 0 for exactly the EXEC cycle.
- req_valid arriving during EXEC, or during RESP with rsp_ready=0, waits; no grant is issued.
- Reset mid-operation: the in-flight operation is discarded, no response is produced, and op_count returns to 0.
- Width rule: all arithmetic is modulo 2^16. Carry-in equals the op bit, so subtract = A + ~B + 1.

Test Plan:
- Reset, then req0 add A=0x1234 B=0x0FFF -> req_ready[0] at T, rsp_valid at T+2, rsp_y=0x2233, rsp_cout=0, rsp_id=0, op_count=1 after handshake.
- req1 add 0xFFFF+0x0001 -> rsp_y=0x0000, rsp_cout=1. req2 sub 0x0005-0x0003 -> rsp_y=0x0002, rsp_cout=1. req3 sub 0x0003-0x0005 -> rsp_y=0xFFFE, rsp_cout=0.
- All four req_valid held high with rsp_ready=1 -> grants in order 0,1,2,3,0 at 2-cycle spacing, each rsp_id matches its grant, rsp_valid low only during EXEC cycles.
- rsp_ready=0 for 5 cycles while req1 is pending -> rsp_y/rsp_id held stable, req_ready stays 0; raise rsp_ready -> response accepted and req1 granted in the same cycle.
- Assert rst_n=0 asynchronously during EXEC -> all outputs zero immediately, no response after release; first grant after reset goes to the lowest valid index starting from 0.
- Force op_count to 0xFFFF, complete one op -> op_count=0x0000.

Source files
------------

// File: rtl/csa_share_arbiter.sv
// Round-robin arbiter sharing one 16-bit carry-select add/subtract unit among NREQ
// requesters; one operation in flight, result returned on a valid/ready channel.

module csa_add16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        mod_i,
   output logic [15:0] y_o,
   output logic        ovf_o
);
   logic [15:0] bx;
   logic [8:0]  lo;
   logic [8:0]  hi0;
   logic [8:0]  hi1;

   // Upper byte is computed for both carry-ins and selected by the lower carry.
   assign bx  = b_i ^ {16{mod_i}};
   assign lo  = {1'b0, a_i[7:0]} + {1'b0, bx[7:0]} + {8'd0, mod_i};
   assign hi0 = {1'b0, a_i[15:8]} + {1'b0, bx[15:8]};
   assign hi1 = {1'b0, a_i[15:8]} + {1'b0, bx[15:8]} + 9'd1;

   assign y_o   = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
   assign ovf_o = lo[8] ? hi1[8] : hi0[8];
endmodule

// state  | meaning
// S_IDLE | no operation outstanding; arbitration window open
// S_EXEC | CSA fed from latched operands; result captured at the edge
// S_RESP | rsp_valid high; handshake reopens the arbitration window
module csa_share_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_op,
   input  logic [16*NREQ-1:0] req_a,
   input  logic [16*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [15:0]       rsp_y,
   output logic              rsp_cout,
   output logic              busy,
   output logic [15:0]       op_count
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]  id_q, rsp_id_q;
   logic [15:0]     a_q, b_q, rsp_y_q, op_count_q;
   logic            op_q, rsp_cout_q;
   logic [15:0]     csa_y;
   logic            csa_ovf;
   logic [NREQ-1:0] rot;
   logic            found;
   logic [IDW:0]    sum;
   logic [IDW-1:0]  win_idx;
   logic [15:0]     win_a, win_b;
   logic            win_op;
   logic            rsp_hs, window, grant;

   csa_add16 u_csa (
      .a_i   (a_q),
      .b_i   (b_q),
      .mod_i (op_q),
      .y_o   (csa_y),
      .ovf_o (csa_ovf)
   );

   // Rotate so bit 0 is the requester at rr_ptr, then take the first set bit.
   always_comb begin
      rot     = NREQ'({req_valid, req_valid} >> rr_ptr_q);
      found   = 1'b0;
      sum     = '0;
      win_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
            win_idx = sum[IDW-1:0];
         end
      end
   end

   always_comb begin
      win_a  = '0;
      win_b  = '0;
      win_op = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == IDW'(i)) begin
            win_a  = req_a[16*i +: 16];
            win_b  = req_b[16*i +: 16];
            win_op = req_op[i];
         end
      end
   end

   assign rsp_hs    = (state_q == S_RESP) && rsp_ready;
   assign window    = (state_q == S_IDLE) || rsp_hs;
   assign grant     = window && found;
   // Gated by rst_n so no grant is presented while reset is held.
   assign req_ready = (grant && rst_n) ? (NREQ'(1) << win_idx) : '0;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         S_IDLE, S_RESP: begin
            if (grant) begin
               state_d  = S_EXEC;
               rr_ptr_d = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
            end else if (rsp_hs) begin
               state_d = S_IDLE;
            end
         end
         S_EXEC:  state_d = S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= 1'b0;
         id_q       <= '0;
         rsp_y_q    <= '0;
         rsp_cout_q <= 1'b0;
         rsp_id_q   <= '0;
         op_count_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         if (grant) begin
            a_q  <= win_a;
            b_q  <= win_b;
            op_q <= win_op;
            id_q <= win_idx;
         end
         if (state_q == S_EXEC) begin
            rsp_y_q    <= csa_y;
            rsp_cout_q <= csa_ovf;
            rsp_id_q   <= id_q;
         end
         if (rsp_hs) op_count_q <= op_count_q + 16'd1;
      end
   end

   assign rsp_valid = (state_q == S_RESP);
   assign busy      = (state_q != S_IDLE);
   assign rsp_id    = rsp_id_q;
   assign rsp_y     = rsp_y_q;
   assign rsp_cout  = rsp_cout_q;
   assign op_count  = op_count_q;
endmodule
